// File: rtl/trace_ctrl_pkg.sv
// Shared definitions for the trigger-clock phase-shift controller:
// FSM states, default psdone timeout and USB register map.
package trace_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STEP      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ERROR     = 3'd4
  } ctrl_state_e;

  localparam int TIMEOUT_DEFAULT = 1023;

  localparam logic [7:0] REG_PHASE_TARGET = 8'h30;
  localparam logic [7:0] REG_PHASE_CTRL   = 8'h31;
  localparam logic [7:0] REG_PHASE_STATUS = 8'h32;

  function automatic logic is_busy_state(input ctrl_state_e s);
    return !(s == ST_IDLE || s == ST_ERROR);
  endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Generic two-flop synchronizer for slow level signals crossing into the local clock.
module cdc_sync_2ff #(
  parameter int pWIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [pWIDTH-1:0] d,
  output logic [pWIDTH-1:0] q
);

  logic [pWIDTH-1:0] meta_q, meta_d;
  logic [pWIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/trigger_clk_phase_ctrl.sv
// Steps the trigger-clock MMCM fine phase one increment at a time until the
// tracked phase matches the host target, gated on MMCM lock.
module trigger_clk_phase_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int pPHASE_WIDTH = 16,
  parameter int pTIMEOUT     = TIMEOUT_DEFAULT,
  parameter int pTO_WIDTH    = 10
) (
  input  logic                    usb_clk,
  input  logic                    resetn,
  input  logic [pPHASE_WIDTH-1:0] I_target,
  input  logic                    I_go,
  input  logic                    I_abort,
  input  logic                    I_clear,
  input  logic                    I_locked,
  output logic                    O_psen,
  output logic                    O_psincdec,
  input  logic                    I_psdone,
  output logic [pPHASE_WIDTH-1:0] O_current,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_error
);

  localparam logic [pTO_WIDTH-1:0] TO_LIMIT = pTO_WIDTH'(pTIMEOUT);

  ctrl_state_e state_q, state_d;
  logic signed [pPHASE_WIDTH-1:0] target_q, target_d;
  logic signed [pPHASE_WIDTH-1:0] current_q, current_d;
  logic signed [pPHASE_WIDTH-1:0] next_cur;
  logic [pTO_WIDTH-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic abort_pend_q, abort_pend_d;
  logic psen_q, psen_d;
  logic psincdec_q, psincdec_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic locked;
  logic step_up;
  logic abort_any;

  cdc_sync_2ff #(.pWIDTH(1)) u_lock_sync (
    .clk   (usb_clk),
    .rst_n (resetn),
    .d     (I_locked),
    .q     (locked)
  );

  assign to_cnt_inc = to_cnt_q + pTO_WIDTH'(1);
  // Target and current are frozen between STEP and psdone, so the step
  // direction can be recomputed instead of stored.
  assign step_up    = target_q > current_q;
  assign abort_any  = abort_pend_q | I_abort;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    current_d    = current_q;
    to_cnt_d     = to_cnt_q;
    abort_pend_d = abort_pend_q;
    error_d      = error_q;
    psen_d       = 1'b0;
    psincdec_d   = 1'b0;
    done_d       = 1'b0;
    next_cur     = step_up ? current_q + pPHASE_WIDTH'(1) : current_q - pPHASE_WIDTH'(1);

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (I_go) begin
          target_d     = I_target;
          error_d      = 1'b0;
          abort_pend_d = 1'b0;
          if (I_target == current_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end else if (state_q == ST_ERROR && I_clear) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOCK: begin
        if (I_abort) begin
          state_d = ST_IDLE;
        end else if (locked) begin
          state_d    = ST_STEP;
          psen_d     = 1'b1;
          psincdec_d = step_up;
          to_cnt_d   = '0;
        end
      end
      // psen is already on the wire here, so an abort must wait for its psdone.
      ST_STEP: begin
        state_d      = ST_WAIT_DONE;
        to_cnt_d     = to_cnt_inc;
        abort_pend_d = I_abort;
      end
      ST_WAIT_DONE: begin
        if (I_psdone) begin
          current_d    = next_cur;
          abort_pend_d = 1'b0;
          if (abort_any) begin
            state_d = ST_IDLE;
          end else if (next_cur == target_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end else if (to_cnt_inc == TO_LIMIT) begin
          error_d      = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = ST_ERROR;
        end else begin
          to_cnt_d     = to_cnt_inc;
          abort_pend_d = abort_any;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = is_busy_state(state_d);
  end

  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      current_q    <= '0;
      to_cnt_q     <= '0;
      abort_pend_q <= 1'b0;
      psen_q       <= 1'b0;
      psincdec_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      current_q    <= current_d;
      to_cnt_q     <= to_cnt_d;
      abort_pend_q <= abort_pend_d;
      psen_q       <= psen_d;
      psincdec_q   <= psincdec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign O_psen     = psen_q;
  assign O_psincdec = psincdec_q;
  assign O_current  = current_q;
  assign O_busy     = busy_q;
  assign O_done     = done_q;
  assign O_error    = error_q;

endmodule
